// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared sizes and source encoding for the writeback arbiter
// Widths, register count, starvation default and the writeback source select.
package regarb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int NREG       = 32;
  localparam int STARVE_MAX = 4;

  typedef enum logic {
    SRC_S0 = 1'b0,
    SRC_S1 = 1'b1
  } src_e;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write bit vector with set-priority update
// One bit per register; bit 0 never sets because x0 is hard-wired to zero.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   look_a,
  input  logic [AW-1:0]   look_b,
  output logic            hit_a,
  output logic            hit_b,
  output logic [NREG-1:0] bits
);
  logic [NREG-1:0] r_bits;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_next;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en) w_set_mask[set_idx] = 1'b1;
    if (clr_en) w_clr_mask[clr_idx] = 1'b1;
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    w_next    = (r_bits & ~w_clr_mask) | w_set_mask;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_bits <= '0;
    else     r_bits <= w_next;
  end

  assign hit_a = r_bits[look_a];
  assign hit_b = r_bits[look_b];
  assign bits  = r_bits;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with hazard scoreboard
// Optional REGARB_BYPASS_EN adds output-stage forwarding ports and drops that term from busy.
module regfile_wb_arbiter
  import regarb_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int REG_AW_P     = REG_AW,
  parameter int STARVE_MAX_P = STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_valid,
  output logic                s0_ready,
  input  logic [REG_AW_P-1:0] s0_rd,
  input  logic [XLEN_P-1:0]   s0_data,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [REG_AW_P-1:0] s1_rd,
  input  logic [XLEN_P-1:0]   s1_data,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [REG_AW_P-1:0] iss_rd,
  input  logic [REG_AW_P-1:0] chk_a1,
  input  logic [REG_AW_P-1:0] chk_a2,
  output logic                busy1,
  output logic                busy2,
  output logic                we3,
  output logic [REG_AW_P-1:0] a3,
  output logic [XLEN_P-1:0]   wd3
`ifdef REGARB_BYPASS_EN
  ,
  output logic                byp1_valid,
  output logic                byp2_valid,
  output logic [XLEN_P-1:0]   byp1_data,
  output logic [XLEN_P-1:0]   byp2_data
`endif
);
  localparam int NREG_P = 1 << REG_AW_P;
  localparam int CNT_W  = 4;

  logic [CNT_W-1:0]    r_starve;
  logic                r_we3;
  logic [REG_AW_P-1:0] r_a3;
  logic [XLEN_P-1:0]   r_wd3;

  logic                w_force1;
  logic                w_acc0;
  logic                w_acc1;
  src_e                w_src;
  logic [REG_AW_P-1:0] w_rd;
  logic [XLEN_P-1:0]   w_data;
  logic                w_iss_fire;
  logic                w_hit1;
  logic                w_hit2;
  logic [NREG_P-1:0]   w_sb_bits;
  logic                w_stage1;
  logic                w_stage2;

  assign w_force1 = (r_starve == CNT_W'(STARVE_MAX_P));
  assign s0_ready = !w_force1;
  assign s1_ready = w_force1 | !s0_valid;
  // The ready terms make acceptance mutually exclusive without extra gating.
  assign w_acc0   = s0_valid && s0_ready;
  assign w_acc1   = s1_valid && s1_ready;

  always_comb begin
    w_src  = w_acc1 ? SRC_S1 : SRC_S0;
    w_rd   = s0_rd;
    w_data = s0_data;
    if (w_src == SRC_S1) begin
      w_rd   = s1_rd;
      w_data = s1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_we3    <= 1'b0;
      r_a3     <= '0;
      r_wd3    <= '0;
    end else begin
      if (w_acc1)
        r_starve <= '0;
      else if (s1_valid && !s1_ready && r_starve != CNT_W'(STARVE_MAX_P))
        r_starve <= r_starve + CNT_W'(1);

      if ((w_acc0 || w_acc1) && w_rd != '0) begin
        r_we3 <= 1'b1;
        r_a3  <= w_rd;
        r_wd3 <= w_data;
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

  assign iss_ready  = !w_sb_bits[iss_rd];
  assign w_iss_fire = iss_valid && iss_ready && iss_rd != '0;

  reg_scoreboard #(
    .NREG (NREG_P),
    .AW   (REG_AW_P)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (w_iss_fire),
    .set_idx (iss_rd),
    .clr_en  (w_acc1),
    .clr_idx (s1_rd),
    .look_a  (chk_a1),
    .look_b  (chk_a2),
    .hit_a   (w_hit1),
    .hit_b   (w_hit2),
    .bits    (w_sb_bits)
  );

  assign w_stage1 = r_we3 && r_a3 == chk_a1;
  assign w_stage2 = r_we3 && r_a3 == chk_a2;

`ifdef REGARB_BYPASS_EN
  assign busy1      = (chk_a1 != '0) && w_hit1;
  assign busy2      = (chk_a2 != '0) && w_hit2;
  assign byp1_valid = w_stage1 && chk_a1 != '0;
  assign byp2_valid = w_stage2 && chk_a2 != '0;
  assign byp1_data  = r_wd3;
  assign byp2_data  = r_wd3;
`else
  assign busy1 = (chk_a1 != '0) && (w_hit1 | w_stage1);
  assign busy2 = (chk_a2 != '0) && (w_hit2 | w_stage2);
`endif

  assign we3 = r_we3;
  assign a3  = r_a3;
  assign wd3 = r_wd3;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port (A3/WD3/WE3) of the 32x32 register file between two writeback sources:
  - s0: the single-cycle core writeback.
  - s1: a multi-cycle unit (divider or load unit).
- Keeps a pending-write scoreboard for registers owned by in-flight long ops.
- Reports read-hazard (busy) status for the two decode read addresses so the core can stall.
- Sits between the execute/writeback stage and the register file.

Parameters:
- XLEN, 32, data width of writeback and WD3.
- REG_AW, 5, register address width (32 registers; x0 hard-wired to zero).
- STARVE_MAX, 4, consecutive stalled cycles of s1 before s1 is force-granted (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- s0_valid  in  1  core writeback request.
- s0_ready  out  1  core writeback accepted this cycle.
- s0_rd  in  REG_AW  core destination register.
- s0_data  in  XLEN  core writeback data.
- s1_valid  in  1  long-op writeback request.
- s1_ready  out  1  long-op writeback accepted this cycle.
- s1_rd  in  REG_AW  long-op destination register.
- s1_data  in  XLEN  long-op writeback data.
- iss_valid  in  1  long op issued; mark iss_rd pending.
- iss_ready  out  1  issue permitted (no WAW on iss_rd).
- iss_rd  in  REG_AW  long-op destination register.
- chk_a1  in  REG_AW  decode read address 1.
- chk_a2  in  REG_AW  decode read address 2.
- busy1  out  1  chk_a1 has an outstanding write.
- busy2  out  1  chk_a2 has an outstanding write.
- we3  out  1  register file write enable (registered).
- a3  out  REG_AW  register file write address (registered).
- wd3  out  XLEN  register file write data (registered).

Behaviour:
- Reset (rst=1 at a clock edge):
  - scoreboard cleared to 0; starvation counter to 0.
  - we3=0, a3=0, wd3=0.
  - Any in-flight output write is dropped.
  - busy1/busy2 read 0 in the cycle after reset.
- Arbitration, combinational ready:
  - force1 = (starve_cnt == STARVE_MAX).
  - s0_ready = !force1.
  - s1_ready = force1 | !s0_valid.
  - At most one of s0 and s1 is accepted per cycle.
- Starvation counter:
  - +1 each cycle s1_valid && !s1_ready.
  - Cleared on any cycle s1 is accepted.
  - Saturates at STARVE_MAX.
  - While force1=1, s0 is held off even if it is valid.
- Output stage (1-cycle latency):
  - An accepted request with rd != 0 loads a3/wd3 and sets we3=1 on the next edge.
  - Otherwise we3=0 on the next edge; a3/wd3 hold their values.
  - An accepted request with rd == 0 is consumed but never asserts we3.
- Scoreboard (bit per register; bit 0 constant 0):
  - iss_valid && iss_ready && iss_rd != 0 sets bit iss_rd.
  - An accepted s1 write clears bit s1_rd.
  - If set and clear hit the same register in the same cycle, set wins.
- iss_ready = !scoreboard[iss_rd]. An issue to a pending register is refused (WAW); iss_rd=0 is always ready.
- busyN = (chk_aN != 0) && (scoreboard[chk_aN] | (we3 && a3 == chk_aN)).
  - Combinational from current state.
  - Covers the registered write that is not yet in the register file.
- s1 writing a register whose scoreboard bit is 0: the write is still performed; the bit stays 0.
- The s0 path does not touch the scoreboard.

Optional Feature:
- Macro: REGARB_BYPASS_EN.
- Defined:
  - Adds outputs byp1_valid, byp2_valid (1 bit each) and byp1_data, byp2_data (XLEN each).
  - bypN_valid = we3 && a3 == chk_aN && chk_aN != 0; bypN_data = wd3.
  - busyN then excludes the output-stage term and reflects the scoreboard only.
- Not defined:
  - The bypass ports are absent.
  - busyN includes the output-stage term as specified above.

Decomposition:
- Shared package regarb_pkg:
  - XLEN, REG_AW, NREG=32, STARVE_MAX default.
  - Source-select encoding SRC_S0=0, SRC_S1=1.
- Sub-module reg_scoreboard: NREG-bit set/clear vector with two combinational lookup ports and set-priority.
- Arbiter, starvation counter and output stage stay in the top level.

Test Plan:
- Reset then s0_valid, s0_rd=5, s0_data=0xDEADBEEF -> s0_ready=1; next cycle we3=1, a3=5, wd3=0xDEADBEEF; following cycle we3=0.
- s0 and s1 both valid for 6 cycles, STARVE_MAX=4 -> s0 granted cycles 0-3; cycle 4 s1_ready=1 and s0_ready=0; counter returns to 0.
- iss_valid, iss_rd=7 -> busy1=1 for chk_a1=7 the next cycle; iss_valid, iss_rd=7 again -> iss_ready=0; s1 writes rd=7 -> busy1 stays 1 one more cycle (output stage), then 0.
- Same cycle: iss_rd=9 issue and s1 accept with s1_rd=9 -> bit 9 remains set; busy2 for chk_a2=9 stays 1.
- s0_rd=0, s0_data=0x1234 -> accepted; we3 stays 0; busy1 for chk_a1=0 always 0.
- iss_rd=3 pending, rst asserted for 1 cycle mid-transfer with we3=1 -> next cycle we3=0, busy1 for chk_a1=3 is 0, iss_ready=1.
